// File: rtl/mac_sequencer.sv
// Demand-driven sequencer for the MAC datapath: clear, accumulate over a
// programmable number of taps, load the output register, then hold under valid/ready.
//
//   state | meaning
//   IDLE  | waiting for sampleStrobe; all strobes low
//   CLEAR | clear accumulator
//   ACCUM | accumulate tap 0..lastTap, one per cycle
//   LOAD  | load output register
//   HOLD  | result valid, waiting for outReady
module mac_sequencer #(
    parameter int NTAPS = 4,
    localparam int SELW = $clog2(NTAPS)
) (
    input  logic            clk1,
    input  logic            reset,
    input  logic            sampleStrobe,
    input  logic [SELW-1:0] tapCount,
    input  logic            outReady,
    input  logic            clrOverrun,
    output logic [SELW-1:0] muxControl,
    output logic            clearAccum,
    output logic            accumEn,
    output logic            loadOut,
    output logic            outValid,
    output logic            busy,
    output logic            overrun
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        ACCUM = 3'd2,
        LOAD  = 3'd3,
        HOLD  = 3'd4
    } state_t;

    state_t          state, state_next;
    logic [SELW-1:0] tap, tap_next;
    logic [SELW-1:0] last_tap, last_tap_next;
    logic            overrun_q;

    always_ff @(posedge clk1) begin
        if (reset) begin
            state     <= IDLE;
            tap       <= '0;
            last_tap  <= '0;
            overrun_q <= 1'b0;
        end else begin
            state    <= state_next;
            tap      <= tap_next;
            last_tap <= last_tap_next;
            // a strobe while busy takes priority over a simultaneous clear
            if (sampleStrobe && (state != IDLE))
                overrun_q <= 1'b1;
            else if (clrOverrun)
                overrun_q <= 1'b0;
        end
    end

    always_comb begin
        state_next    = state;
        tap_next      = tap;
        last_tap_next = last_tap;
        case (state)
            IDLE: begin
                if (sampleStrobe) begin
                    last_tap_next = tapCount;
                    tap_next      = '0;
                    state_next    = CLEAR;
                end
            end
            CLEAR: state_next = ACCUM;
            ACCUM: begin
                if (tap == last_tap)
                    state_next = LOAD;
                else
                    tap_next = tap + SELW'(1);
            end
            LOAD: state_next = HOLD;
            HOLD: begin
                if (outReady)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        muxControl = '0;
        clearAccum = 1'b0;
        accumEn    = 1'b0;
        loadOut    = 1'b0;
        outValid   = 1'b0;
        case (state)
            CLEAR: clearAccum = 1'b1;
            ACCUM: begin
                accumEn    = 1'b1;
                muxControl = tap;
            end
            LOAD: begin
                loadOut    = 1'b1;
                muxControl = last_tap;
            end
            HOLD: begin
                outValid   = 1'b1;
                muxControl = last_tap;
            end
            default: ;
        endcase
    end

    assign busy    = (state != IDLE);
    assign overrun = overrun_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Scoreboard bench for mac_sequencer: accepted passes are queued by a pass-level
// model and a negedge monitor checks every output against the pass schedule.
module tb_mac_sequencer;

    localparam int NTAPS = 4;
    localparam int SELW  = $clog2(NTAPS);

    logic            clk1;
    logic            reset;
    logic            sampleStrobe;
    logic [SELW-1:0] tapCount;
    logic            outReady;
    logic            clrOverrun;
    logic [SELW-1:0] muxControl;
    logic            clearAccum;
    logic            accumEn;
    logic            loadOut;
    logic            outValid;
    logic            busy;
    logic            overrun;

    mac_sequencer #(.NTAPS(NTAPS)) dut (
        .clk1         (clk1),
        .reset        (reset),
        .sampleStrobe (sampleStrobe),
        .tapCount     (tapCount),
        .outReady     (outReady),
        .clrOverrun   (clrOverrun),
        .muxControl   (muxControl),
        .clearAccum   (clearAccum),
        .accumEn      (accumEn),
        .loadOut      (loadOut),
        .outValid     (outValid),
        .busy         (busy),
        .overrun      (overrun)
    );

    initial begin
        clk1 = 1'b0;
        forever #5 clk1 = ~clk1;
    end

    typedef struct {
        int e;   // cycle index of the CLEAR cycle
        int n;   // taps in this pass
    } pass_t;

    pass_t sb[$];
    int    cyc        = 0;
    bit    m_active   = 1'b0;
    int    m_e        = 0;
    int    m_n        = 0;
    bit    m_ov       = 1'b0;
    int    n_checks   = 0;
    int    n_fail     = 0;
    int    loads_seen = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    // pass-level model: which strobes are accepted, when a pass ends, overrun flag
    always @(posedge clk1) begin
        cyc <= cyc + 1;
        if (reset) begin
            m_active <= 1'b0;
            m_ov     <= 1'b0;
            sb.delete();
        end else begin
            if (sampleStrobe && m_active)
                m_ov <= 1'b1;
            else if (clrOverrun)
                m_ov <= 1'b0;
            if (m_active) begin
                if ((cyc - m_e >= m_n + 2) && outReady)
                    m_active <= 1'b0;
            end else if (sampleStrobe) begin
                m_active <= 1'b1;
                m_e      <= cyc + 1;
                m_n      <= int'(tapCount) + 1;
                sb.push_back('{cyc + 1, int'(tapCount) + 1});
            end
        end
    end

    pass_t p;
    int    d;
    bit    e_clr, e_acc, e_load, e_val, e_busy, mux_known;
    int    e_mux;

    always @(negedge clk1) begin
        e_clr = 0; e_acc = 0; e_load = 0; e_val = 0; e_busy = 0;
        e_mux = 0; mux_known = 1;
        if (sb.size() > 0) begin
            p      = sb[0];
            d      = cyc - p.e;
            e_busy = 1;
            e_clr  = (d == 0);
            e_acc  = (d >= 1) && (d <= p.n);
            e_load = (d == p.n + 1);
            e_val  = (d >= p.n + 2);
            if (e_acc)       e_mux = d - 1;
            else if (e_load) e_mux = p.n - 1;
            else if (e_val)  mux_known = 0;
        end
        chk("clearAccum", int'(clearAccum), int'(e_clr));
        chk("accumEn",    int'(accumEn),    int'(e_acc));
        chk("loadOut",    int'(loadOut),    int'(e_load));
        chk("outValid",   int'(outValid),   int'(e_val));
        chk("busy",       int'(busy),       int'(e_busy));
        chk("overrun",    int'(overrun),    int'(m_ov));
        if (mux_known)
            chk("muxControl", int'(muxControl), e_mux);
        if (loadOut)
            loads_seen++;
        if (e_val && outReady && !reset)
            void'(sb.pop_front());
    end

    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    task automatic strobe(input int tc);
        sampleStrobe = 1'b1;
        tapCount     = SELW'(tc);
        step();
        sampleStrobe = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && (busy !== 1'b0); i++)
            step();
        chk("wait_idle_timeout", int'(busy), 0);
    endtask

    int loads0;
    int tc;

    initial begin
        reset        = 1'b1;
        sampleStrobe = 1'b0;
        tapCount     = '0;
        outReady     = 1'b0;
        clrOverrun   = 1'b0;
        repeat (3) step();
        chk("reset_busy", int'(busy), 0);
        chk("reset_mux",  int'(muxControl), 0);
        reset = 1'b0;
        step();

        // full-length pass
        outReady = 1'b1;
        strobe(3);
        wait_idle();
        step();

        // single tap, tapCount changed mid-pass
        strobe(0);
        tapCount = 2'd2;
        step();
        wait_idle();
        step();

        // backpressure
        outReady = 1'b0;
        strobe(2);
        repeat (3 + 2 + 10) step();
        chk("bp_outValid", int'(outValid), 1);
        outReady = 1'b1;
        step();
        chk("bp_release_busy", int'(busy), 0);

        // overrun while busy, then clear with simultaneous strobe, then clear alone
        strobe(3);
        step();
        sampleStrobe = 1'b1;
        step();
        sampleStrobe = 1'b0;
        chk("overrun_set", int'(overrun), 1);
        wait_idle();
        outReady = 1'b0;
        strobe(1);
        step();
        sampleStrobe = 1'b1;
        clrOverrun   = 1'b1;
        step();
        sampleStrobe = 1'b0;
        clrOverrun   = 1'b0;
        chk("overrun_set_wins", int'(overrun), 1);
        clrOverrun = 1'b1;
        step();
        clrOverrun = 1'b0;
        chk("overrun_cleared", int'(overrun), 0);
        outReady = 1'b1;
        wait_idle();

        // reset during ACCUM at tap 2
        strobe(3);
        repeat (3) step();
        chk("abort_tap", int'(muxControl), 2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_busy", int'(busy), 0);
        strobe(1);
        step();
        chk("restart_tap0", int'(muxControl), 0);
        wait_idle();

        // back-to-back at minimum spacing
        loads0 = loads_seen;
        for (int k = 0; k < 8; k++) begin
            tc = int'($urandom_range(0, NTAPS - 1));
            strobe(tc);
            repeat (tc + 1 + 3) step();
        end
        step();
        chk("b2b_loads", loads_seen - loads0, 8);
        chk("b2b_overrun", int'(overrun), 0);

        // randomized traffic
        for (int k = 0; k < 500; k++) begin
            sampleStrobe = ($urandom_range(0, 4) == 0);
            tapCount     = SELW'($urandom_range(0, NTAPS - 1));
            outReady     = ($urandom_range(0, 2) != 0);
            clrOverrun   = ($urandom_range(0, 6) == 0);
            reset        = ($urandom_range(0, 96) == 0);
            step();
        end
        sampleStrobe = 1'b0;
        clrOverrun   = 1'b0;
        reset        = 1'b0;
        outReady     = 1'b1;
        wait_idle();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
